axis_frame_gen: RTL
===================

Name: axis_frame_gen

Overview:
AXI4-Stream frame transmitter; drives the input side of an axis_fifo or any AXI-Stream sink. Emits a programmed number of frames of programmed byte length, with a deterministic byte pattern, partial tkeep on the last beat and a programmable inter-frame gap. Used as a traffic source in loopback and bring-up paths, and as the stimulus end for FIFO/frame-mode verification.

Parameters:
DATA_WIDTH, 8, tdata width in bits; must be a multiple of 8
KEEP_WIDTH, DATA_WIDTH/8, byte lanes per beat
LEN_WIDTH, 16, width of frame length (bytes) and gap/count fields
USER_WIDTH, 1, tuser width
USER_BAD_FRAME_VALUE, 1'b1, tuser value driven on the last beat of a frame marked bad

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cfg_start  in  1  single-cycle start request; sampled only in IDLE
cfg_stop  in  1  single-cycle stop request; finish current frame, then IDLE
cfg_len  in  LEN_WIDTH  frame length in bytes; 0 treated as 1
cfg_count  in  LEN_WIDTH  frames to send; 0 = continuous until stop
cfg_gap  in  LEN_WIDTH  idle cycles between frames
cfg_seed  in  8  pattern seed
cfg_bad_interval  in  LEN_WIDTH  mark every Nth frame bad; 0 = never (only with feature)
m_axis_tdata  out  DATA_WIDTH  frame data
m_axis_tkeep  out  KEEP_WIDTH  byte enables
m_axis_tvalid  out  1  beat valid
m_axis_tready  in  1  sink ready
m_axis_tlast  out  1  last beat of frame
m_axis_tuser  out  USER_WIDTH  bad-frame marker on last beat, else 0
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse on return to IDLE
frame_cnt  out  LEN_WIDTH  frames completed since last start; wraps

Behaviour:
- Reset: tvalid=0, tlast=0, tkeep=0, tdata=0, tuser=0, busy=0, done=0, frame_cnt=0, FSM=IDLE. Reset mid-frame drops tvalid next edge; no tlast emitted (the sink must also be reset).
- cfg_* latched on accepted start; changes during a run are ignored.
- FSM: IDLE -> SEND on cfg_start. SEND -> GAP on tlast handshake if cfg_gap>0 and more frames remain; SEND -> SEND (back-to-back, no bubble) if cfg_gap=0 and frames remain; SEND -> IDLE when count reached or stop pending. GAP counts cfg_gap cycles with tvalid=0, then SEND, or IDLE if stop pending.
- cfg_start while busy: ignored. cfg_stop in IDLE: ignored. cfg_stop in GAP: IDLE next cycle. cfg_stop in SEND: latched; the frame completes normally.
- First beat tvalid=1 the cycle after start is accepted (1-cycle latency).
- Handshake: transfer when tvalid&&tready. While tvalid=1 and tready=0, all m_axis_* stay stable. tvalid is never deasserted mid-frame.
- Pattern: byte i of frame f (f = 0-based index since start) = (cfg_seed + f + i) mod 256, lane 0 = lowest byte. Beats per frame = ceil(L/KEEP_WIDTH).
- tkeep: all ones except the last beat, where the low (L mod KEEP_WIDTH) bits are set; all ones if the remainder is 0. Unused lanes on the last beat drive 0.
- frame_cnt increments on each tlast handshake and clears on start. done pulses in the cycle the FSM enters IDLE from SEND/GAP. busy drops in that same cycle.
- Byte and beat counters are LEN_WIDTH wide. L up to 2^LEN_WIDTH-1 is legal. Count wrap in continuous mode is harmless.

Optional Feature:
- Macro AXIS_FRAME_GEN_BAD_FRAME_EN.
- Defined: when cfg_bad_interval=N>0, frames with (f+1) mod N == 0 drive tuser=USER_BAD_FRAME_VALUE on their last beat, 0 elsewhere.
- Undefined: tuser is constant 0 and cfg_bad_interval is unused. All other behaviour is identical.

Decomposition:
- Shared package axis_gen_pkg holds: FSM state enum (IDLE, SEND, GAP), the localparam for byte-lane count, and the tkeep-from-remainder function.
- One natural sub-module: axis_gen_pattern. It is combinational/registered and produces the tdata/tkeep beat from seed, frame index, byte offset and remaining length. The FSM and counters stay in the top.

Test Plan:
- DATA_WIDTH=32, len=10, count=2, gap=0, seed=0x10, tready=1 -> 6 beats, no bubble. Frame0 beat0 data=0x13121110; beat2 tkeep=0x3, tlast=1. Frame1 starts at 0x11. done pulses once. frame_cnt=2.
- Same config but tready toggling 1/0 every cycle -> outputs held stable during stalls. Identical byte stream.
- len=4, count=0, gap=3, stop asserted mid-frame 5 -> frame 5 completes with tlast, then IDLE, done=1, frame_cnt=6. Exactly 3 idle cycles between frames.
- len=0, count=1 -> single beat, tkeep=0x1, tlast=1. cfg_start while busy has no effect.
- rst asserted during beat 2 of a 16-byte frame -> tvalid=0, busy=0, frame_cnt=0 next cycle. A new start produces a fresh frame 0.
- With AXIS_FRAME_GEN_BAD_FRAME_EN, bad_interval=3, count=6 -> tuser=1 only on the last beat of frames 2 and 5. When fed through axis_fifo (FRAME_FIFO=1, DROP_BAD_FRAME=1), 4 frames emerge.

Source files
------------

// File: rtl/axis_gen_pkg.sv
// rtl/axis_gen_pkg.sv - shared FSM states, lane constants and tkeep helper for axis_frame_gen
package axis_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } gen_state_t;

    localparam int GEN_BYTE_W   = 8;
    localparam int GEN_MAX_KEEP = 64;

    // rem == 0 means a full beat; otherwise only the low rem lanes are enabled
    function automatic logic [GEN_MAX_KEEP-1:0] keep_from_rem(input int rem, input int lanes);
        logic [GEN_MAX_KEEP-1:0] k;
        k = '0;
        for (int i = 0; i < GEN_MAX_KEEP; i++) begin
            if ((rem == 0 && i < lanes) || i < rem) k[i] = 1'b1;
        end
        return k;
    endfunction

endpackage

// File: rtl/axis_gen_pattern.sv
// rtl/axis_gen_pattern.sv - combinational beat builder: tdata/tkeep/last from seed, frame, offset, remaining
module axis_gen_pattern
    import axis_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = DATA_WIDTH / GEN_BYTE_W,
    parameter int LEN_WIDTH  = 16
) (
    input  logic [7:0]            seed,
    input  logic [7:0]            frame_idx,
    input  logic [7:0]            offset,
    input  logic [LEN_WIDTH-1:0]  remaining,
    output logic [DATA_WIDTH-1:0] tdata,
    output logic [KEEP_WIDTH-1:0] tkeep,
    output logic                  last
);

    localparam logic [LEN_WIDTH-1:0] LANES = LEN_WIDTH'(KEEP_WIDTH);

    logic [7:0] base;
    int         rem;

    assign base = seed + frame_idx + offset;
    assign last = (remaining <= LANES);
    assign rem  = (last && remaining != LANES) ? int'(remaining) : 0;

    always_comb begin
        tkeep = KEEP_WIDTH'(keep_from_rem(rem, KEEP_WIDTH));
        tdata = '0;
        for (int j = 0; j < KEEP_WIDTH; j++) begin
            if (tkeep[j]) tdata[j*GEN_BYTE_W +: GEN_BYTE_W] = base + 8'(j);
        end
    end

endmodule

// File: rtl/axis_frame_gen.sv
// rtl/axis_frame_gen.sv - AXI-Stream frame generator: FSM, config latch, frame/byte counters
// Optional tuser bad-frame marking enabled by defining AXIS_FRAME_GEN_BAD_FRAME_EN
module axis_frame_gen
    import axis_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = DATA_WIDTH / GEN_BYTE_W,
    parameter int LEN_WIDTH  = 16,
    parameter int USER_WIDTH = 1,
    parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = USER_WIDTH'(1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic                  cfg_stop,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic [LEN_WIDTH-1:0]  cfg_count,
    input  logic [LEN_WIDTH-1:0]  cfg_gap,
    input  logic [7:0]            cfg_seed,
    input  logic [LEN_WIDTH-1:0]  cfg_bad_interval,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  frame_cnt
);

    localparam logic [LEN_WIDTH-1:0] ONE   = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] LANES = LEN_WIDTH'(KEEP_WIDTH);

    gen_state_t            state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, count_q, gap_q, gap_cnt_q;
    logic [LEN_WIDTH-1:0]  offset_q, remaining_q, frame_cnt_q, len_eff;
    logic [7:0]            seed_q;
    logic                  stop_pend_q, done_q;
    logic                  beat_last, fire, end_of_frame, more_frames;
    logic [DATA_WIDTH-1:0] pat_data;
    logic [KEEP_WIDTH-1:0] pat_keep;

    assign len_eff      = (cfg_len == '0) ? ONE : cfg_len;
    assign m_axis_tvalid = (state_q == SEND);
    assign fire         = m_axis_tvalid && m_axis_tready;
    assign end_of_frame = fire && beat_last;
    assign more_frames  = (count_q == '0) || ((frame_cnt_q + ONE) != count_q);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = (state_q != IDLE);
        unique case (state_q)
            IDLE: if (cfg_start) state_d = SEND;
            SEND: begin
                if (end_of_frame) begin
                    if (stop_pend_q || cfg_stop || !more_frames) state_d = IDLE;
                    else if (gap_q != '0)                       state_d = GAP;
                end
            end
            GAP: begin
                if (cfg_stop)               state_d = IDLE;
                else if (gap_cnt_q <= ONE)  state_d = SEND;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q       <= '0;
            count_q     <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            seed_q      <= '0;
            offset_q    <= '0;
            remaining_q <= '0;
            frame_cnt_q <= '0;
            stop_pend_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= (state_q != IDLE) && (state_d == IDLE);
            case (state_q)
                IDLE: if (cfg_start) begin
                    len_q       <= len_eff;
                    remaining_q <= len_eff;
                    count_q     <= cfg_count;
                    gap_q       <= cfg_gap;
                    seed_q      <= cfg_seed;
                    offset_q    <= '0;
                    frame_cnt_q <= '0;
                    stop_pend_q <= 1'b0;
                end
                SEND: begin
                    if (cfg_stop) stop_pend_q <= 1'b1;
                    if (fire) begin
                        if (beat_last) begin
                            frame_cnt_q <= frame_cnt_q + ONE;
                            offset_q    <= '0;
                            remaining_q <= len_q;
                            gap_cnt_q   <= gap_q;
                        end else begin
                            offset_q    <= offset_q + LANES;
                            remaining_q <= remaining_q - LANES;
                        end
                    end
                end
                GAP: gap_cnt_q <= gap_cnt_q - ONE;
                default: ;
            endcase
        end
    end

    axis_gen_pattern #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (KEEP_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_pattern (
        .seed      (seed_q),
        .frame_idx (8'(frame_cnt_q)),
        .offset    (8'(offset_q)),
        .remaining (remaining_q),
        .tdata     (pat_data),
        .tkeep     (pat_keep),
        .last      (beat_last)
    );

    assign m_axis_tdata = m_axis_tvalid ? pat_data : '0;
    assign m_axis_tkeep = m_axis_tvalid ? pat_keep : '0;
    assign m_axis_tlast = m_axis_tvalid && beat_last;
    assign done         = done_q;
    assign frame_cnt    = frame_cnt_q;

`ifdef AXIS_FRAME_GEN_BAD_FRAME_EN
    // bad_phase_q tracks (f+1) mod N as a 1..N counter to avoid a divider
    logic [LEN_WIDTH-1:0] bad_int_q, bad_phase_q;
    logic                 frame_bad;

    assign frame_bad = (bad_int_q != '0) && (bad_phase_q == bad_int_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            bad_int_q   <= '0;
            bad_phase_q <= '0;
        end else if (state_q == IDLE && cfg_start) begin
            bad_int_q   <= cfg_bad_interval;
            bad_phase_q <= ONE;
        end else if (end_of_frame) begin
            bad_phase_q <= frame_bad ? ONE : bad_phase_q + ONE;
        end
    end

    assign m_axis_tuser = (m_axis_tlast && frame_bad) ? USER_BAD_FRAME_VALUE : '0;
`else
    logic unused_bad_interval;
    assign unused_bad_interval = ^cfg_bad_interval;
    assign m_axis_tuser        = '0;
`endif

endmodule
